// File: rtl/mem_io_pkg.sv
// Shared address map, STATUS field positions and region decode type for mem_io_bus.
package mem_io_pkg;

  localparam logic [31:0] FIFO_DATA_ADDR = 32'h0000_1000;
  localparam logic [31:0] STATUS_ADDR    = 32'h0000_1004;
  localparam logic [31:0] CYCLES_ADDR    = 32'h0000_1008;
  localparam logic [31:0] DROPS_ADDR     = 32'h0000_100C;

  localparam int unsigned STATUS_EMPTY_BIT = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;
  localparam int unsigned STATUS_FLUSH_BIT = 0;
  localparam int unsigned STATUS_COUNT_LSB = 8;
  localparam int unsigned STATUS_COUNT_MSB = 15;

  typedef enum logic [2:0] {
    RAM,
    FIFO,
    STATUS,
    CYCLES,
    DROPS,
    NONE
  } region_e;

endpackage

// File: rtl/out_fifo.sv
// Output word FIFO with flush; a push while full is accepted only alongside a pop.
module out_fifo #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [31:0]                   push_data,
  input  logic                          pop,
  input  logic                          flush,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic [31:0]                   head
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW + 1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_io_bus.sv
// Data RAM plus peripheral page (output FIFO, STATUS, DROPS, optional CYCLES).
// Define MEM_IO_CYCLE_COUNTER_EN to build the free-running CYCLES register.
module mem_io_bus
  import mem_io_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  logic [31:0]                 ram [RAM_WORDS];
  logic [AW-1:0]               ram_idx;
  region_e                     region;
  logic                        push;
  logic                        pop;
  logic                        flush;
  logic                        full;
  logic                        empty;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic [31:0]                 drops;
  logic [31:0]                 status;
  logic                        unused_low_bits;

  assign unused_low_bits = ^ALUResult[1:0];
  assign ram_idx         = ALUResult[AW+1:2];

  always_comb begin
    region = NONE;
    if ((ALUResult >> (AW + 2)) == 32'd0) begin
      region = RAM;
    end else begin
      case ({ALUResult[31:2], 2'b00})
        FIFO_DATA_ADDR: region = FIFO;
        STATUS_ADDR:    region = STATUS;
`ifdef MEM_IO_CYCLE_COUNTER_EN
        CYCLES_ADDR:    region = CYCLES;
`endif
        DROPS_ADDR:     region = DROPS;
        default:        region = NONE;
      endcase
    end
  end

  assign push      = MemWrite && (region == FIFO);
  assign flush     = MemWrite && (region == STATUS) && WriteData[STATUS_FLUSH_BIT];
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  out_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (push),
    .push_data(WriteData),
    .pop      (pop),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .head     (out_data)
  );

  always_ff @(posedge clk) begin
    if (MemWrite && (region == RAM)) ram[ram_idx] <= WriteData;
  end

  // A push that coincides with a pop is accepted even when full, so it is not a drop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drops <= '0;
    end else if (MemWrite && (region == DROPS)) begin
      drops <= '0;
    end else if (push && full && !pop && (drops != '1)) begin
      drops <= drops + 1'b1;
    end
  end

`ifdef MEM_IO_CYCLE_COUNTER_EN
  logic [31:0] cycles;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles <= '0;
    end else if (MemWrite && (region == CYCLES)) begin
      cycles <= WriteData;
    end else begin
      cycles <= cycles + 1'b1;
    end
  end
`endif

  always_comb begin
    status                                    = '0;
    status[STATUS_EMPTY_BIT]                  = empty;
    status[STATUS_FULL_BIT]                   = full;
    status[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = 8'(count);
  end

  always_comb begin
    ReadData = '0;
    case (region)
      RAM:     ReadData = ram[ram_idx];
      STATUS:  ReadData = status;
`ifdef MEM_IO_CYCLE_COUNTER_EN
      CYCLES:  ReadData = cycles;
`endif
      DROPS:   ReadData = drops;
      default: ReadData = '0;
    endcase
  end

endmodule

// File: tb/tb_mem_io_bus.sv
// Directed self-checking bench for mem_io_bus; CYCLES expectations follow MEM_IO_CYCLE_COUNTER_EN.
module tb_mem_io_bus;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  mem_io_bus #(.RAM_WORDS(256), .FIFO_DEPTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .ALUResult(ALUResult),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Present a store for one edge; returns 1 time unit after that edge.
  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    MemWrite  = 1'b1;
    ALUResult = addr;
    WriteData = data;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
  endtask

  task automatic load_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    ALUResult = addr;
    #1;
    check(tag, ReadData, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_word;

  initial begin
    reset     = 1'b0;
    MemWrite  = 1'b0;
    ALUResult = '0;
    WriteData = '0;
    out_ready = 1'b0;
    #6 reset = 1'b1;

    // reset state
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    load_check("rst_status", 32'h1004, 32'h0000_0001);
    load_check("rst_drops", 32'h100C, 32'h0);

    // RAM and unmapped
    store(32'h10, 32'hDEAD_BEEF);
    load_check("ram_rd", 32'h10, 32'hDEAD_BEEF);
    load_check("ram_rd_unaligned", 32'h13, 32'hDEAD_BEEF);
    store(32'h2000, 32'h1234_5678);
    load_check("unmapped_rd", 32'h2000, 32'h0);
    load_check("fifo_data_rd", 32'h1000, 32'h0);

    // fill with back-pressure
    store(32'h1000, 32'd1);
    check("push_valid_latency", {31'd0, out_valid}, 32'd1);
    check("first_head", out_data, 32'd1);
    for (int i = 2; i <= 8; i++) store(32'h1000, 32'(i));
    load_check("full_status", 32'h1004, 32'h0000_0802);
    store(32'h1000, 32'd9);
    load_check("drop_one", 32'h100C, 32'd1);
    load_check("still_full", 32'h1004, 32'h0000_0802);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain_valid_%0d", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("drain_data_%0d", i), out_data, 32'(i));
      tick();
    end
    out_ready = 1'b0;
    check("drained_valid", {31'd0, out_valid}, 32'd0);
    load_check("drained_status", 32'h1004, 32'h0000_0001);

    // simultaneous push and pop while full
    for (int i = 1; i <= 8; i++) store(32'h1000, 32'(i));
    out_ready = 1'b1;
    store(32'h1000, 32'hA5);
    out_ready = 1'b0;
    load_check("pp_full_status", 32'h1004, 32'h0000_0802);
    load_check("pp_drops", 32'h100C, 32'd1);
    out_ready = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      exp_word = (i == 9) ? 32'hA5 : 32'(i);
      check($sformatf("pp_data_%0d", i), out_data, exp_word);
      tick();
    end
    out_ready = 1'b0;
    check("pp_empty", {31'd0, out_valid}, 32'd0);

    // flush after wrapping pointers
    for (int i = 0; i < 5; i++) store(32'h1000, 32'h50 + 32'(i));
    out_ready = 1'b1;
    repeat (5) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(32'h1000, 32'h60 + 32'(i));
    load_check("pre_flush_status", 32'h1004, 32'h0000_0300);
    check("pre_flush_head", out_data, 32'h60);
    store(32'h1004, 32'h0000_0001);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    load_check("flush_status", 32'h1004, 32'h0000_0001);
    store(32'h1000, 32'h77);
    check("post_flush_data", out_data, 32'h77);
    load_check("post_flush_status", 32'h1004, 32'h0000_0100);
    store(32'h1004, 32'h0000_0002);
    load_check("status_nonflush_store", 32'h1004, 32'h0000_0100);

    // DROPS clear, then mid-operation reset
    store(32'h100C, 32'h0);
    load_check("drops_cleared", 32'h100C, 32'd0);
    for (int i = 0; i < 9; i++) store(32'h1000, 32'h80 + 32'(i));
    load_check("drops_two", 32'h100C, 32'd2);
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    load_check("four_queued", 32'h1004, 32'h0000_0400);
    tick();
    reset = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    #1 reset = 1'b1;
    load_check("rel_status", 32'h1004, 32'h0000_0001);
    load_check("rel_drops", 32'h100C, 32'd0);
    load_check("rel_cycles", 32'h1008, 32'd0);

    // cycle counter
    store(32'h1008, 32'hFFFF_FFFE);
`ifdef MEM_IO_CYCLE_COUNTER_EN
    load_check("cyc_loaded", 32'h1008, 32'hFFFF_FFFE);
    tick();
    load_check("cyc_plus1", 32'h1008, 32'hFFFF_FFFF);
    tick();
    load_check("cyc_wrap", 32'h1008, 32'h0000_0000);
    tick();
    load_check("cyc_after_wrap", 32'h1008, 32'h0000_0001);
`else
    load_check("cyc_loaded", 32'h1008, 32'h0);
    tick();
    load_check("cyc_plus1", 32'h1008, 32'h0);
    tick();
    load_check("cyc_wrap", 32'h1008, 32'h0);
`endif
    load_check("ram_retained", 32'h10, 32'hDEAD_BEEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
